// File: rtl/nes_pal_pkg.sv
// ============================================================================
//  Package     : nes_pal_pkg
//  Description : Shared types for the custom-palette download path: the
//                palette entry carried through the FIFO, the number of
//                entries in a palette, and the loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nes_pal_pkg;

  localparam int PAL_ENTRIES = 64;
  localparam int PAL_IDX_W   = 6;
  localparam int PAL_RGB_W   = 15;

  // One palette RAM write: entry index plus BGR555 colour {B,G,R}.
  typedef struct packed {
    logic [PAL_IDX_W-1:0] idx;
    logic [PAL_RGB_W-1:0] rgb;
  } pal_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } pal_ld_state_t;

endpackage

`default_nettype wire

// File: rtl/pal_entry_fifo.sv
// ============================================================================
//  Module      : pal_entry_fifo
//  Description : Synchronous show-ahead FIFO of palette entries. The head
//                entry is visible on pop_data whenever the FIFO is not empty.
//  Ports       : clk, reset_n (async, active-low)
//                flush          - synchronous clear of all entries
//                push/push_data - write one entry (dropped when full unless
//                                 a pop happens in the same cycle)
//                pop/pop_data   - consume the head entry
//                empty, count   - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pal_entry_fifo
  import nes_pal_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          push,
  input  pal_entry_t                    push_data,
  input  logic                          pop,
  output pal_entry_t                    pop_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  pal_entry_t  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_full;
  logic        w_do_push;
  logic        w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = r_wr_ptr - r_rd_ptr;
  assign empty    = (count == '0);
  assign w_full   = (count == (AW+1)'(FIFO_DEPTH));
  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands and the occupancy stays unchanged.
  assign w_do_push = push & (~w_full | w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/palette_load_ctrl.sv
// ============================================================================
//  Module      : palette_load_ctrl
//  Description : Custom-palette download sequencer. Assembles download bytes
//                into BGR555 entries, buffers them, and writes them to the
//                palette RAM only during vertical blank (when VBL_GATE=1),
//                with at least one idle cycle between writes.
//  Ports       : clk, reset_n (async, active-low)
//                dl_active/dl_wr/dl_addr/dl_data - download byte stream
//                dl_wait                          - back-pressure to source
//                vblank                           - write window
//                load_color/_index/_data          - palette RAM write port
//                busy, done, short_file           - status
//  Config      : PAL_RGB24_EN defined  -> 24-bit RGB triplet input format
//                PAL_RGB24_EN undefined-> 16-bit little-endian BGR555 words
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_load_ctrl
  import nes_pal_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int VBL_GATE   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [8:0]  dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  input  logic        vblank,
  output logic        load_color,
  output logic [5:0]  load_color_index,
  output logic [14:0] load_color_data,
  output logic        busy,
  output logic        done,
  output logic        short_file
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pal_ld_state_t r_state;
  pal_ld_state_t w_next;

  logic          r_dl_active_q;
  logic          w_dl_rise;
  logic          w_byte_ok;
  logic          w_push;
  pal_entry_t    w_push_entry;
  pal_entry_t    w_head;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic          w_drain_state;
  logic          w_win_open;
  logic          w_pop;

  logic          r_load_color;
  logic [5:0]    r_idx;
  logic [14:0]   r_data;
  logic [6:0]    r_entry_cnt;
  logic          r_short;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_dl_active_q <= 1'b0;
    else          r_dl_active_q <= dl_active;
  end

  assign w_dl_rise = dl_active & ~r_dl_active_q;

  // --------------------------------------------------------------------------
  // Byte assembler. A byte arriving in the same cycle as the dl_active rise
  // would collide with the flush, so it is ignored.
  // --------------------------------------------------------------------------
`ifdef PAL_RGB24_EN
  logic [1:0] r_phase;
  logic [5:0] r_trip;
  logic [4:0] r_red;
  logic [4:0] r_grn;

  assign w_byte_ok        = dl_active & dl_wr & ~w_dl_rise & (dl_addr < 9'd192);
  assign w_push           = w_byte_ok & (r_phase == 2'd2);
  assign w_push_entry.idx = r_trip;
  assign w_push_entry.rgb = {dl_data[7:3], r_grn, r_red};

  // Running triplet position replaces addr%3 and addr/3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
      r_trip  <= '0;
      r_red   <= '0;
      r_grn   <= '0;
    end else if (w_dl_rise) begin
      r_phase <= '0;
      r_trip  <= '0;
      r_red   <= '0;
      r_grn   <= '0;
    end else if (w_byte_ok) begin
      case (r_phase)
        2'd0: begin
          r_red   <= dl_data[7:3];
          r_phase <= 2'd1;
        end
        2'd1: begin
          r_grn   <= dl_data[7:3];
          r_phase <= 2'd2;
        end
        default: begin
          r_phase <= 2'd0;
          r_trip  <= r_trip + 1'b1;
        end
      endcase
    end
  end
`else
  logic [7:0] r_held;
  logic       unused_bit15;

  // Bit 7 of the odd byte is colour bit 15, which BGR555 has no room for.
  assign unused_bit15     = dl_data[7];
  assign w_byte_ok        = dl_active & dl_wr & ~w_dl_rise & (dl_addr < 9'd128);
  assign w_push           = w_byte_ok & dl_addr[0];
  assign w_push_entry.idx = dl_addr[6:1];
  assign w_push_entry.rgb = {dl_data[6:0], r_held};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_held <= '0;
    else if (w_dl_rise)                 r_held <= '0;
    else if (w_byte_ok && !dl_addr[0])  r_held <= dl_data;
  end
`endif

  pal_entry_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (w_dl_rise),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  // One slot of headroom so a byte already launched by the source still fits.
  assign dl_wait = (w_fifo_count >= CW'(FIFO_DEPTH - 1));

  // --------------------------------------------------------------------------
  // Drain engine. A pop launches a registered write on the following cycle;
  // refusing to pop while that write is on the bus forces the idle gap.
  // --------------------------------------------------------------------------
  assign w_drain_state = (r_state == COLLECT) || (r_state == DRAIN);
  assign w_win_open    = (VBL_GATE == 0) ? 1'b1 : vblank;
  assign w_pop         = w_drain_state & ~w_fifo_empty & w_win_open &
                         ~r_load_color & ~w_dl_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_color <= 1'b0;
      r_idx        <= '0;
      r_data       <= '0;
    end else begin
      r_load_color <= w_pop;
      if (w_pop) begin
        r_idx  <= w_head.idx;
        r_data <= w_head.rgb;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_entry_cnt <= '0;
    else if (w_dl_rise)
      r_entry_cnt <= '0;
    else if (w_push && (r_entry_cnt != 7'(PAL_ENTRIES)))
      r_entry_cnt <= r_entry_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_short <= 1'b0;
    else if (w_dl_rise)
      r_short <= 1'b0;
    else if ((r_state == DRAIN) && (w_next == DONE))
      r_short <= (r_entry_cnt < 7'(PAL_ENTRIES));
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    busy   = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_dl_rise) w_next = COLLECT;
      end
      COLLECT: begin
        if (!dl_active) w_next = DRAIN;
      end
      DRAIN: begin
        // A new download abandons the queued entries without signalling done.
        if (w_dl_rise)
          w_next = COLLECT;
        else if (w_fifo_empty && !r_load_color)
          w_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (w_dl_rise) w_next = COLLECT;
        else           w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign load_color       = r_load_color;
  assign load_color_index = r_idx;
  assign load_color_data  = r_data;
  assign short_file       = r_short;

endmodule

`default_nettype wire

// File: tb/tb_palette_load_ctrl.sv
// ============================================================================
//  Module      : tb_palette_load_ctrl
//  Description : Self-checking bench for palette_load_ctrl (default 16-bit
//                word format). Expected palette writes are queued when the
//                completing byte is issued; a monitor compares every
//                load_color pulse against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_palette_load_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [8:0]  dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_wait;
  logic        vblank = 1'b0;
  logic        load_color;
  logic [5:0]  load_color_index;
  logic [14:0] load_color_data;
  logic        busy;
  logic        done;
  logic        short_file;

  palette_load_ctrl #(.FIFO_DEPTH(8), .VBL_GATE(1)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .dl_active        (dl_active),
    .dl_wr            (dl_wr),
    .dl_addr          (dl_addr),
    .dl_data          (dl_data),
    .dl_wait          (dl_wait),
    .vblank           (vblank),
    .load_color       (load_color),
    .load_color_index (load_color_index),
    .load_color_data  (load_color_data),
    .busy             (busy),
    .done             (done),
    .short_file       (short_file)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [20:0] exp_q [$];     // {index, data}
  logic [7:0]  held_m;
  int          pushed_cnt;
  int          stall_at;

  // Monitor state
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic        prev_lc  = 1'b0;
  logic        prev_vb  = 1'b0;
  logic [14:0] dut_wr [64];
  logic [20:0] m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (load_color) begin
        wr_cnt++;
        dut_wr[load_color_index] = load_color_data;
        chk("write_gap", {31'd0, prev_lc}, 32'd0);
        chk("write_in_vblank", {31'd0, prev_vb}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("write_index", {26'd0, load_color_index}, {26'd0, m_e[20:15]});
          chk("write_data",  {17'd0, load_color_data},  {17'd0, m_e[14:0]});
        end
      end
    end
    prev_lc = load_color;
    prev_vb = vblank;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_download();
    held_m     = 8'h00;
    pushed_cnt = 0;
    stall_at   = -1;
    dl_active  = 1'b1;
    tick();
  endtask

  task automatic send_byte(input int addr, input logic [7:0] d);
    int guard = 0;
    while (dl_wait) begin
      if (stall_at < 0) stall_at = pushed_cnt;
      tick();
      guard++;
      if (guard > 2000) begin
        chk("dl_wait_timeout", 32'd1, 32'd0);
        return;
      end
    end
    dl_wr   = 1'b1;
    dl_addr = addr[8:0];
    dl_data = d;
    // Palette rule: even byte is the low byte, odd byte supplies bits 14:8.
    if (addr < 128) begin
      if (addr % 2 == 0) begin
        held_m = d;
      end else begin
        exp_q.push_back({6'(addr / 2), 15'(int'(d & 8'h7F) * 256 + int'(held_m))});
        pushed_cnt++;
      end
    end
    tick();
    dl_wr = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_random(input int first, input int n);
    for (int a = first; a < first + n; a++) send_byte(a, 8'($urandom));
  endtask

  task automatic finish_download(input int exp_done);
    int d0 = done_cnt;
    int g  = 0;
    dl_active = 1'b0;
    while (busy && g < 3000) begin
      tick();
      g++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    tick();
    chk("done_pulses", done_cnt - d0, exp_done);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int d0;

    // Reset state
    repeat (3) tick();
    chk("rst_load_color", {31'd0, load_color}, 32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_dl_wait",    {31'd0, dl_wait},    32'd0);
    chk("rst_short",      {31'd0, short_file}, 32'd0);
    chk("rst_index",      {26'd0, load_color_index}, 32'd0);
    chk("rst_data",       {17'd0, load_color_data},  32'd0);
    reset_n = 1'b1;
    tick();

    // 1: full download, vblank steady high, plus ignored bytes past 128
    vblank = 1'b1;
    w0 = wr_cnt;
    start_download();
    send_random(0, 10);
    send_byte(10, 8'h1F);
    send_byte(11, 8'h00);
    send_random(12, 116);
    send_random(128, 4);
    finish_download(1);
    chk("t1_writes", wr_cnt - w0, 32'd64);
    chk("t1_entry5", {17'd0, dut_wr[5]}, 32'h001F);
    chk("t1_short",  {31'd0, short_file}, 32'd0);

    // 2: vblank low stalls the download; raising it lets everything through
    vblank = 1'b0;
    w0 = wr_cnt;
    start_download();
    fork
      send_random(0, 128);
      begin
        repeat (80) tick();
        chk("t2_no_write_outside_vblank", wr_cnt - w0, 32'd0);
        chk("t2_dl_wait_high", {31'd0, dl_wait}, 32'd1);
        vblank = 1'b1;
      end
    join
    chk("t2_stall_after_7", stall_at, 32'd7);
    finish_download(1);
    chk("t2_writes", wr_cnt - w0, 32'd64);
    chk("t2_short",  {31'd0, short_file}, 32'd0);

    // 3: short file
    w0 = wr_cnt;
    start_download();
    send_random(0, 20);
    finish_download(1);
    chk("t3_writes", wr_cnt - w0, 32'd10);
    chk("t3_short",  {31'd0, short_file}, 32'd1);

    // 4: asynchronous reset in DRAIN with 4 entries queued
    vblank = 1'b0;
    w0 = wr_cnt;
    start_download();
    send_random(0, 8);
    dl_active = 1'b0;
    repeat (3) tick();
    chk("t4_busy_drain", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_rst_busy",    {31'd0, busy},       32'd0);
    chk("t4_rst_lc",      {31'd0, load_color}, 32'd0);
    chk("t4_rst_dl_wait", {31'd0, dl_wait},    32'd0);
    chk("t4_rst_short",   {31'd0, short_file}, 32'd0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    vblank  = 1'b1;
    repeat (30) tick();
    chk("t4_no_writes", wr_cnt - w0, 32'd0);
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // 5: restart during DRAIN discards queued entries, no done pulse
    vblank = 1'b0;
    start_download();
    send_random(0, 10);
    dl_active = 1'b0;
    repeat (4) tick();
    d0 = done_cnt;
    exp_q.delete();
    w0 = wr_cnt;
    start_download();
    repeat (3) tick();
    chk("t5_no_done", done_cnt - d0, 32'd0);
    chk("t5_busy",    {31'd0, busy}, 32'd1);
    vblank = 1'b1;
    send_random(0, 128);
    finish_download(1);
    chk("t5_writes", wr_cnt - w0, 32'd64);
    chk("t5_short",  {31'd0, short_file}, 32'd0);

    // 7: odd byte with no preceding even byte uses the cleared held value
    w0 = wr_cnt;
    start_download();
    send_byte(3, 8'hD5);
    send_byte(4, 8'h3C);
    send_byte(5, 8'h81);
    finish_download(1);
    chk("t7_writes", wr_cnt - w0, 32'd2);
    chk("t7_entry1", {17'd0, dut_wr[1]}, 32'h5500);
    chk("t7_entry2", {17'd0, dut_wr[2]}, 32'h013C);
    chk("t7_short",  {31'd0, short_file}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
